dut_chain_checker: RTL

//  Downstream consumer of the dut_fsm chain in the SEU test bench. Delays the stimulus word
//  fed into the chain by the chain latency and compares it with the chain output every cycle.

---
 rtl/dut_chk_pkg.sv | 18 +
 rtl/dut_delay_line.sv | 25 ++
 rtl/dut_chain_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dut_chk_pkg.sv
// Shared types and helpers for the chain checker: FSM state encoding and
// the sizing function for the flush counter.
package dut_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    CHECK = 2'd2
  } chk_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dut_delay_line.sv
// Plain registered shift line: dout is din delayed by DEPTH_G clock cycles.
module dut_delay_line #(
  parameter int WIDTH_G = 4,
  parameter int DEPTH_G = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH_G-1:0] din,
  output logic [WIDTH_G-1:0] dout
);

  logic [WIDTH_G-1:0] stage [DEPTH_G];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH_G; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH_G; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH_G-1];

endmodule

// File: rtl/dut_chain_checker.sv
// Compares the chain output against the latency-matched stimulus word and
// accumulates error statistics (count, sticky bit flags, first bad word).
module dut_chain_checker
  import dut_chk_pkg::*;
#(
  parameter int IO_SIZE_G = 4,
  parameter int LATENCY_G = 16,
  parameter int CNT_W_G   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [IO_SIZE_G-1:0] ref_i,
  input  logic [IO_SIZE_G-1:0] data_i,
  output logic                 checking_o,
  output logic                 err_o,
  output logic [CNT_W_G-1:0]   err_cnt_o,
  output logic                 cnt_sat_o,
  output logic [IO_SIZE_G-1:0] err_bits_o,
  output logic [IO_SIZE_G-1:0] first_err_data_o,
  output logic                 first_err_vld_o
);

  localparam int FC_W = (clog2(LATENCY_G) > 0) ? clog2(LATENCY_G) : 1;
  localparam logic [FC_W-1:0]    FC_LOAD = FC_W'(LATENCY_G - 1);
  localparam logic [CNT_W_G-1:0] CNT_MAX = '1;

  chk_state_t          state, state_nxt;
  logic [FC_W-1:0]     fcnt, fcnt_nxt;
  logic [IO_SIZE_G-1:0] exp_dat;
  logic [IO_SIZE_G-1:0] diff;
  logic                mism;

  logic [CNT_W_G-1:0]   cnt_base, cnt_nxt;
  logic                 sat_base, sat_nxt;
  logic [IO_SIZE_G-1:0] bits_base, bits_nxt;
  logic [IO_SIZE_G-1:0] fd_base, fd_nxt;
  logic                 fv_base, fv_nxt;

  dut_delay_line #(
    .WIDTH_G (IO_SIZE_G),
    .DEPTH_G (LATENCY_G)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .din    (ref_i),
    .dout   (exp_dat)
  );

  // Dropping enable always returns to IDLE, so a mid-flush drop restarts the flush.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (!en_i) begin
      state_nxt = IDLE;
      fcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = FLUSH;
          fcnt_nxt  = FC_LOAD;
        end
        FLUSH: begin
          if (fcnt == '0) state_nxt = CHECK;
          else            fcnt_nxt  = fcnt - FC_W'(1);
        end
        CHECK:   state_nxt = CHECK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  assign checking_o = (state == CHECK);
  assign diff       = exp_dat ^ data_i;
  assign mism       = (state == CHECK) && (diff != '0);

  // Clear is applied first so a mismatch in the same cycle lands on fresh accumulators.
  always_comb begin
    cnt_base  = clr_i ? '0 : err_cnt_o;
    sat_base  = clr_i ? 1'b0 : cnt_sat_o;
    bits_base = clr_i ? '0 : err_bits_o;
    fd_base   = clr_i ? '0 : first_err_data_o;
    fv_base   = clr_i ? 1'b0 : first_err_vld_o;
    cnt_nxt   = cnt_base;
    sat_nxt   = sat_base;
    bits_nxt  = bits_base;
    fd_nxt    = fd_base;
    fv_nxt    = fv_base;
    if (mism) begin
      if (cnt_base != CNT_MAX) cnt_nxt = cnt_base + CNT_W_G'(1);
      sat_nxt  = sat_base | (cnt_nxt == CNT_MAX);
      bits_nxt = bits_base | diff;
      if (!fv_base) begin
        fd_nxt = data_i;
        fv_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      cnt_sat_o        <= 1'b0;
      err_bits_o       <= '0;
      first_err_data_o <= '0;
      first_err_vld_o  <= 1'b0;
    end else begin
      err_o            <= mism;
      err_cnt_o        <= cnt_nxt;
      cnt_sat_o        <= sat_nxt;
      err_bits_o       <= bits_nxt;
      first_err_data_o <= fd_nxt;
      first_err_vld_o  <= fv_nxt;
    end
  end

endmodule
